// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Purpose  : Direct-mapped, write-back / write-allocate data cache with one
//            128-bit line (4 words) per set and a line-granular memory port.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache #(
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_input_valid,
    input  logic [31:0]  addr,
    input  logic         mem_rw,
    input  logic [31:0]  din,
    output logic         is_ready,
    output logic         is_output_valid,
    output logic [31:0]  dout,
    output logic         is_hit,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_write,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 28 - IW;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPARE   = 3'd1,
        S_WRITEBACK = 3'd2,
        S_ALLOCATE  = 3'd3,
        S_WAIT_FILL = 3'd4
    } state_t;

    state_t              state_q;

    // Latched request (byte-offset bits are never needed)
    logic [31:2]         req_addr_q;
    logic [31:0]         req_din_q;
    logic                req_rw_q;
    logic                miss_q;

    // Cache storage
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TW-1:0]       tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];

    // Registered outputs
    logic                ready_q;
    logic                out_valid_q;
    logic                hit_q;
    logic [31:0]         dout_q;
    logic                mreq_valid_q;
    logic                mreq_write_q;
    logic [31:0]         mreq_addr_q;
    logic [127:0]        mreq_data_q;
    logic [31:0]         hit_cnt_q;
    logic [31:0]         miss_cnt_q;

    // Lookup of the incoming request, so a hit can be flagged on acceptance
    logic [IW-1:0]       in_idx;
    logic [TW-1:0]       in_tag;
    logic [6:0]          in_bit;
    logic                in_hit;
    logic [31:0]         in_word;

    // Lookup of the latched request
    logic [IW-1:0]       req_idx;
    logic [TW-1:0]       req_tag;
    logic [6:0]          req_bit;
    logic                req_hit;
    logic [31:0]         victim_addr;
    logic [31:0]         fill_addr;

    // Byte-select bits carry no meaning for a word-addressed cache
    logic                unused_byte_bits;
    assign unused_byte_bits = ^addr[1:0];

    assign in_idx      = addr[4 +: IW];
    assign in_tag      = addr[4 + IW +: TW];
    assign in_bit      = {addr[3:2], 5'b0};
    assign in_hit      = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign in_word     = data_q[in_idx][in_bit +: 32];

    assign req_idx     = req_addr_q[4 +: IW];
    assign req_tag     = req_addr_q[4 + IW +: TW];
    assign req_bit     = {req_addr_q[3:2], 5'b0};
    assign req_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_addr = {tag_q[req_idx], req_idx, 4'b0};
    assign fill_addr   = {req_addr_q[31:4], 4'b0};

    assign is_ready        = ready_q;
    assign is_output_valid = out_valid_q;
    assign is_hit          = hit_q;
    assign dout            = dout_q;
    assign mem_req_valid   = mreq_valid_q;
    assign mem_req_write   = mreq_write_q;
    assign mem_req_addr    = mreq_addr_q;
    assign mem_req_data    = mreq_data_q;
    assign hit_count       = hit_cnt_q;
    assign miss_count      = miss_cnt_q;

    // Controller FSM; completion outputs are registered on the edge entering
    // COMPARE when that COMPARE is known to hit, giving a pulse in COMPARE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_q       <= 1'b0;
            req_addr_q   <= '0;
            req_din_q    <= '0;
            req_rw_q     <= 1'b0;
            ready_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            dout_q       <= '0;
            mreq_valid_q <= 1'b0;
            mreq_write_q <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_data_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            dout_q      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (is_input_valid) begin
                        req_addr_q <= addr[31:2];
                        req_din_q  <= din;
                        req_rw_q   <= mem_rw;
                        miss_q     <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= S_COMPARE;
                        if (in_hit) begin
                            out_valid_q <= 1'b1;
                            hit_q       <= 1'b1;
                            dout_q      <= mem_rw ? 32'd0 : in_word;
                        end
                    end
                end
                S_COMPARE: begin
                    if (req_hit) begin
                        if (req_rw_q) begin
                            data_q[req_idx][req_bit +: 32] <= req_din_q;
                            dirty_q[req_idx]               <= 1'b1;
                        end
                        if (miss_q) miss_cnt_q <= miss_cnt_q + 32'd1;
                        else        hit_cnt_q  <= hit_cnt_q + 32'd1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        miss_q       <= 1'b1;
                        mreq_valid_q <= 1'b1;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            mreq_write_q <= 1'b1;
                            mreq_addr_q  <= victim_addr;
                            mreq_data_q  <= data_q[req_idx];
                            state_q      <= S_WRITEBACK;
                        end else begin
                            mreq_write_q <= 1'b0;
                            mreq_addr_q  <= fill_addr;
                            mreq_data_q  <= '0;
                            state_q      <= S_ALLOCATE;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_req_ready) begin
                        mreq_write_q <= 1'b0;
                        mreq_addr_q  <= fill_addr;
                        mreq_data_q  <= '0;
                        state_q      <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_req_ready) begin
                        mreq_valid_q <= 1'b0;
                        state_q      <= S_WAIT_FILL;
                    end
                end
                S_WAIT_FILL: begin
                    if (mem_resp_valid) begin
                        data_q[req_idx]  <= mem_resp_data;
                        tag_q[req_idx]   <= req_tag;
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                        out_valid_q      <= 1'b1;
                        dout_q           <= req_rw_q ? 32'd0 : mem_resp_data[req_bit +: 32];
                        state_q          <= S_COMPARE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache
// Purpose  : Self-checking bench for data_cache against a transaction-level
//            cache/memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    localparam int NS = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_rw;
    logic [31:0]  din;
    logic         is_ready;
    logic         is_output_valid;
    logic [31:0]  dout;
    logic         is_hit;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    data_cache #(.NUM_SETS(NS)) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_rw          (mem_rw),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .is_hit          (is_hit),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per-set residency by line address, plus backing memory
    logic         mv    [NS];
    logic         md    [NS];
    logic [31:0]  mline [NS];
    logic [127:0] mdat  [NS];
    logic [127:0] mem   [logic [31:0]];
    int unsigned  exp_hits;
    int unsigned  exp_misses;

    // Results observed during the last transaction
    logic [31:0]  got_dout;
    logic         got_hit;
    int           got_lat;
    int           n_wb;
    int           n_fill;
    logic [31:0]  wb_a_obs;
    logic [127:0] wb_d_obs;
    logic [31:0]  fill_a_obs;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] get_line(input logic [31:0] la);
        if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
        return mem[la];
    endfunction

    task automatic wait_ready();
        int c = 0;
        while (is_ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
    endtask

    // One complete CPU request, serving the memory port, then model check
    task automatic transact(input logic [31:0] a, input logic rw, input logic [31:0] wd, input int stall);
        logic [31:0]  la;
        int           idx;
        int           off;
        logic         exp_hit;
        logic         exp_wb;
        logic [31:0]  wb_a;
        logic [127:0] wb_d;
        logic [31:0]  exp_dout;
        int           cyc;
        bit           done;
        bit           stalled;
        bit           fill_pend;
        int           sl;
        logic         pw;
        logic [31:0]  pa;

        la      = {a[31:4], 4'b0};
        idx     = int'((a >> 4) % NS);
        off     = int'(a[3:2]);
        exp_hit = mv[idx] && (mline[idx] == la);
        exp_wb  = !exp_hit && mv[idx] && md[idx];
        wb_a    = mline[idx];
        wb_d    = mdat[idx];
        if (!exp_hit) begin
            if (exp_wb) mem[wb_a] = wb_d;
            mdat[idx]  = get_line(la);
            mv[idx]    = 1'b1;
            md[idx]    = 1'b0;
            mline[idx] = la;
        end
        exp_dout = mdat[idx][off*32 +: 32];
        if (rw) begin
            mdat[idx][off*32 +: 32] = wd;
            md[idx] = 1'b1;
        end
        if (exp_hit) exp_hits++;
        else         exp_misses++;

        wait_ready();
        is_input_valid = 1'b1;
        addr   = a;
        mem_rw = rw;
        din    = wd;
        @(posedge clk);
        @(negedge clk);
        is_input_valid = 1'b0;
        addr = $urandom;
        din  = $urandom;

        cyc = 0; done = 0; stalled = 0; fill_pend = 0; sl = 0;
        pw = 1'b0; pa = '0;
        n_wb = 0; n_fill = 0; got_dout = '0; got_hit = 1'bx; got_lat = -1;
        while (!done && cyc < 300) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (is_output_valid === 1'b1) begin
                done     = 1;
                got_dout = dout;
                got_hit  = is_hit;
                got_lat  = cyc;
            end else begin
                check("quiet_outputs", {is_hit, dout}, '0);
                check("busy_not_ready", is_ready, 1'b0);
                if (mem_req_valid === 1'b1) begin
                    if (stalled) check("req_stable", {mem_req_write, mem_req_addr}, {pw, pa});
                    if (!stalled) sl = stall;
                    if (sl > 0) begin
                        sl--;
                        stalled = 1;
                        pw = mem_req_write;
                        pa = mem_req_addr;
                    end else begin
                        mem_req_ready = 1'b1;
                        stalled = 0;
                        if (mem_req_write) begin
                            n_wb++;
                            wb_a_obs = mem_req_addr;
                            wb_d_obs = mem_req_data;
                        end else begin
                            n_fill++;
                            fill_a_obs = mem_req_addr;
                            fill_pend  = 1;
                        end
                    end
                end else if (fill_pend) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = get_line(fill_a_obs);
                    fill_pend = 0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        check("completed", done, 1'b1);
        check("is_hit", got_hit, exp_hit);
        if (exp_hit) check("hit_latency", got_lat, 0);
        if (!rw) check("dout", got_dout, exp_dout);
        check("writeback_count", n_wb, exp_wb ? 1 : 0);
        check("fill_count", n_fill, exp_hit ? 0 : 1);
        if (exp_wb && n_wb == 1) begin
            check("writeback_addr", wb_a_obs, wb_a);
            check("writeback_data", wb_d_obs, wb_d);
        end
        if (!exp_hit && n_fill == 1) check("fill_addr", fill_a_obs, la);

        @(negedge clk);
        check("single_pulse", is_output_valid, 1'b0);
        check("ready_after", is_ready, 1'b1);
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          idx;
        bit          saw_fill;
        int          cyc;

        reset = 1'b1; is_input_valid = 1'b0; addr = '0; mem_rw = 1'b0; din = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        for (int i = 0; i < NS; i++) begin
            mv[i] = 1'b0; md[i] = 1'b0; mline[i] = '0; mdat[i] = '0;
        end
        exp_hits = 0; exp_misses = 0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", is_ready, 1'b1);
        check("rst_out_valid", {is_output_valid, is_hit, dout}, '0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_counters", {hit_count, miss_count}, '0);

        // Cold read miss with a known line
        mem[32'h100] = {32'd4, 32'd3, 32'd2, 32'd1};
        transact(32'h100, 1'b0, 32'h0, 0);
        check("cold_fill_addr", fill_a_obs, 32'h100);
        check("cold_dout", got_dout, 32'd1);
        check("cold_is_hit", got_hit, 1'b0);
        check("cold_miss_count", miss_count, 32'd1);

        // Re-read within the same line hits
        transact(32'h108, 1'b0, 32'h0, 0);
        check("reread_dout", got_dout, 32'd3);
        check("reread_is_hit", got_hit, 1'b1);
        check("reread_no_mem", n_wb + n_fill, 0);
        check("reread_hit_count", hit_count, 32'd1);

        // Write hit, then conflict miss forces a writeback of the dirty line
        transact(32'h104, 1'b1, 32'hDEADBEEF, 0);
        transact(32'h100 + NS * 16, 1'b0, 32'h0, 0);
        check("evict_wb_addr", wb_a_obs, 32'h100);
        check("evict_wb_word1", wb_d_obs[63:32], 32'hDEADBEEF);
        check("evict_fill_addr", fill_a_obs, 32'h100 + NS * 16);

        // Fill request held off for five cycles
        transact(32'h100 + 2 * NS * 16, 1'b0, 32'h0, 5);

        // Random mix over a small tag pool to exercise hits and evictions
        for (int t = 0; t < 150; t++) begin
            a = ($urandom_range(0, 3) * NS * 16) + ($urandom_range(0, NS - 1) * 16)
              + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3);
            transact(a, 1'(($urandom_range(0, 1))), $urandom, $urandom_range(0, 2));
        end

        // Reset while waiting for a fill: transaction aborted, response ignored
        a   = 32'h5550_0020;
        idx = int'((a >> 4) % NS);
        if (mv[idx] && md[idx]) mem[mline[idx]] = mdat[idx];
        wait_ready();
        is_input_valid = 1'b1; addr = a; mem_rw = 1'b0;
        @(posedge clk);
        @(negedge clk);
        is_input_valid = 1'b0;
        saw_fill = 0; cyc = 0;
        while (!saw_fill && cyc < 50) begin
            mem_req_ready = 1'b0;
            if (mem_req_valid === 1'b1) begin
                mem_req_ready = 1'b1;
                if (mem_req_write === 1'b0) saw_fill = 1;
            end
            @(negedge clk);
            cyc++;
        end
        mem_req_ready = 1'b0;
        check("abort_reached_fill", saw_fill, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = get_line({a[31:4], 4'b0});
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_no_output", is_output_valid, 1'b0);
            check("abort_ready", is_ready, 1'b1);
            check("abort_counters", {hit_count, miss_count}, '0);
            check("abort_no_mem_req", mem_req_valid, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < NS; i++) begin
            mv[i] = 1'b0; md[i] = 1'b0;
        end
        exp_hits = 0; exp_misses = 0;
        transact(a, 1'b0, 32'h0, 0);
        check("abort_reread_misses", got_hit, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have parameter NUM_SETS, default 16, giving the number of direct-mapped sets (power of two, 2..256).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- is_input_valid  in  1  CPU request present
- addr  in  32  byte address
- mem_rw  in  1  1 = write, 0 = read
- din  in  32  CPU write word
- is_ready  out  1  request may be accepted this cycle
- is_output_valid  out  1  single-cycle completion pulse
- dout  out  32  read word
- is_hit  out  1  request completed without a miss
- mem_req_valid  out  1  backing-memory request
- mem_req_ready  in  1  backing-memory accept
- mem_req_write  out  1  1 = line writeback, 0 = line fill
- mem_req_addr  out  32  line-aligned address
- mem_req_data  out  128  writeback line
- mem_resp_valid  in  1  fill data present
- mem_resp_data  in  128  fill line
- hit_count  out  32  completed hits
- miss_count  out  32  completed misses

Function
REQ-003 Address split SHALL be: offset = addr[3:2] (word in line); addr[1:0] ignored; index = addr[4+IW-1:4] with IW = log2(NUM_SETS); tag = remaining upper bits.
REQ-004 Line word w SHALL occupy bits [32w+31:32w] of the 128-bit line.
REQ-005 Each set SHALL hold valid, dirty, tag and 128-bit data; policy SHALL be write-back, write-allocate.
REQ-006 FSM states SHALL be IDLE, COMPARE, WRITEBACK, ALLOCATE and WAIT_FILL.
REQ-007 is_ready SHALL be 1 only in IDLE.
REQ-008 IDLE: a request SHALL be accepted when is_input_valid && is_ready; addr, mem_rw and din SHALL be latched, the miss flag cleared, and the next state SHALL be COMPARE.
REQ-009 COMPARE, hit (valid && tag match):
- is_output_valid = 1 for exactly this cycle
- is_hit = !miss flag
- a read drives dout = the addressed word
- a write updates the addressed word and sets dirty at the clock edge
- next state IDLE
REQ-010 Hit latency SHALL therefore be one cycle: output in the cycle after acceptance.
REQ-011 COMPARE, miss: the miss flag SHALL be set; next state SHALL be WRITEBACK if the victim is valid && dirty, else ALLOCATE.
REQ-012 WRITEBACK SHALL drive:
- mem_req_valid = 1, mem_req_write = 1
- mem_req_addr = {victim tag, index, 4'b0}
- mem_req_data = victim line
On mem_req_valid && mem_req_ready the next state SHALL be ALLOCATE; the writeback is posted, with no response.
REQ-013 ALLOCATE SHALL drive mem_req_valid = 1, mem_req_write = 0 and mem_req_addr = {req tag, index, 4'b0}; on handshake the next state SHALL be WAIT_FILL.
REQ-014 WAIT_FILL: on mem_resp_valid the line SHALL be written with mem_resp_data, valid = 1, dirty = 0 and tag = req tag; the next state SHALL be COMPARE, which then hits and completes with is_hit = 0.
REQ-015 mem_req_* outputs SHALL hold stable while mem_req_valid && !mem_req_ready; mem_req_valid SHALL be 0 in IDLE, COMPARE and WAIT_FILL.
REQ-016 mem_resp_valid outside WAIT_FILL SHALL be ignored.
REQ-017 is_input_valid while is_ready = 0 SHALL be ignored; the requester holds the request until accepted.
REQ-018 is_output_valid, is_hit and dout SHALL be 0 in every cycle without completion.
REQ-019 Counters:
- on each completion, hit_count increments if is_hit, else miss_count increments
- each is a 32-bit counter that wraps from 0xFFFFFFFF to 0

Reset
REQ-020 While reset is high at a clock edge, the block SHALL clear:
- FSM state to IDLE
- all valid and dirty bits
- miss flag
- hit_count and miss_count
- outputs: is_output_valid, is_hit, dout and mem_req_valid to 0; is_ready reads 1 after reset
REQ-021 Reset during WRITEBACK, ALLOCATE or WAIT_FILL SHALL abort the transaction: no completion pulse, no cache update, and a pending fill response SHALL be ignored.

Verification
REQ-022 Cold read addr=0x100, fill returns line {W3..W0}={4,3,2,1}:
- mem_req read at addr 0x100
- then one is_output_valid with dout=1, is_hit=0
- miss_count=1
REQ-023 Re-read addr=0x108 right after REQ-022 -> output in the cycle after acceptance with dout=3, is_hit=1, no mem_req; hit_count=1.
REQ-024 Write 0xDEADBEEF to 0x104 (hit), then read addr 0x100+NUM_SETS*16 (same index, new tag):
- writeback first, mem_req_addr=0x100, mem_req_data word1=0xDEADBEEF
- then a fill at 0x100+NUM_SETS*16
REQ-025 Hold mem_req_ready=0 for 5 cycles in ALLOCATE -> mem_req_valid and mem_req_addr stable all 5 cycles; is_ready=0 throughout.
REQ-026 Assert reset in WAIT_FILL, then pulse mem_resp_valid -> no is_output_valid, is_ready=1, counters 0, and a following read of the same address misses.
